// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out stage fed by the pipo register.
// A word is taken through a valid/ready load handshake and shifted out one
// bit per clock with serial_valid and a serial_last marker on the final bit.
// Back-to-back loads during the final-bit cycle stream with no idle gap.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the data bits) after the data, making the frame N+1 bits long.
module piso_serializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic [N-1:0] parallel_in,
  output logic         load_ready,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         serial_last,
  output logic         busy
);

`ifdef PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(F - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [F-1:0]  sreg;       // bits still to be sent, next bit at the top
  logic [CW-1:0] cnt;        // index of the bit currently on serial_out
  logic [N-1:0]  data_ord;   // data in emission order, first bit at the top
  logic [F-1:0]  frame;      // full frame in emission order
  logic          load_fire;
  logic          at_last;

  // Reorder the incoming word so the first bit to send sits at the MSB.
  always_comb begin
    data_ord = parallel_in;
    if (!MSB_FIRST)
      for (int i = 0; i < N; i++) data_ord[i] = parallel_in[N-1-i];
  end

`ifdef PISO_PARITY_EN
  assign frame = {data_ord, ^parallel_in};
`else
  assign frame = data_ord;
`endif

  assign at_last = (state == SHIFT) && (cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake; ready reopens on the final bit for streaming.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    load_fire  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load_fire = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_IDX) begin
          load_ready = 1'b1;
          if (load_valid) load_fire = 1'b1;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath: capture on load, advance one bit per cycle, clear at end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg         <= '0;
      cnt          <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      serial_last  <= 1'b0;
      busy         <= 1'b0;
    end else if (load_fire) begin
      serial_out   <= frame[F-1];
      sreg         <= {frame[F-2:0], 1'b0};
      cnt          <= '0;
      serial_valid <= 1'b1;
      serial_last  <= 1'b0;            // frame is always at least 2 bits
      busy         <= 1'b1;
    end else if (at_last) begin
      sreg         <= '0;
      cnt          <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      serial_last  <= 1'b0;
      busy         <= 1'b0;
    end else if (state == SHIFT) begin
      serial_out   <= sreg[F-1];
      sreg         <= {sreg[F-2:0], 1'b0};
      cnt          <= cnt + CW'(1);
      serial_last  <= ((cnt + CW'(1)) == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first
// instance. Stimulus pushes expected {bit,last} pairs; a negedge monitor
// pops and compares whenever serial_valid is high.
module tb_piso_serializer;
  localparam int N = 4;
`ifdef PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lv_m, lv_l;
  logic [N-1:0] pi_m, pi_l;
  logic lr_m, so_m, sv_m, sl_m, bz_m;
  logic lr_l, so_l, sv_l, sl_l, bz_l;

  int n_chk  = 0;
  int n_pass = 0;
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic [1:0] e_m, e_l;

  always #5 clk = ~clk;

  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .load_valid(lv_m), .parallel_in(pi_m),
    .load_ready(lr_m), .serial_out(so_m), .serial_valid(sv_m),
    .serial_last(sl_m), .busy(bz_m));

  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(lv_l), .parallel_in(pi_l),
    .load_ready(lr_l), .serial_out(so_l), .serial_valid(sv_l),
    .serial_last(sl_l), .busy(bz_l));

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {bit,last}=%b expected %b", name, act, exp);
  endtask

  // Expected frame for a word: data bits in emission order, then parity.
  task automatic push_frame(input bit lsb, input logic [N-1:0] d);
    logic [1:0] e;
    logic b;
    for (int i = 0; i < N; i++) begin
      b = lsb ? d[i] : d[N-1-i];
      e = {b, (i == N-1) && (F == N)};
      if (lsb) q_l.push_back(e); else q_m.push_back(e);
    end
`ifdef PISO_PARITY_EN
    if (lsb) q_l.push_back({^d, 1'b1}); else q_m.push_back({^d, 1'b1});
`endif
  endtask

  // Present a word for one edge (called with ready known high), then
  // scramble parallel_in to show mid-frame changes are ignored.
  task automatic load(input bit lsb, input logic [N-1:0] d);
    if (lsb) begin lv_l = 1'b1; pi_l = d; end
    else     begin lv_m = 1'b1; pi_m = d; end
    push_frame(lsb, d);
    @(posedge clk); #1;
    lv_m = 1'b0; lv_l = 1'b0;
    pi_m = N'($urandom); pi_l = N'($urandom);
  endtask

  task automatic check_idle(input string name);
    check1({name, "_valid_m"}, sv_m, 1'b0);
    check1({name, "_out_m"},   so_m, 1'b0);
    check1({name, "_last_m"},  sl_m, 1'b0);
    check1({name, "_busy_m"},  bz_m, 1'b0);
    check1({name, "_ready_m"}, lr_m, 1'b1);
    check1({name, "_valid_l"}, sv_l, 1'b0);
    check1({name, "_out_l"},   so_l, 1'b0);
    check1({name, "_busy_l"},  bz_l, 1'b0);
    check1({name, "_ready_l"}, lr_l, 1'b1);
  endtask

  // Monitor: every valid bit must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (sv_m) begin
      if (q_m.size() == 0) begin
        n_chk++;
        $display("FAIL msb_unexpected_bit: got bit %b with nothing expected", so_m);
      end else begin
        e_m = q_m.pop_front();
        check2("msb_bit", {so_m, sl_m}, e_m);
      end
    end else check1("msb_last_without_valid", sl_m, 1'b0);
    if (sv_l) begin
      if (q_l.size() == 0) begin
        n_chk++;
        $display("FAIL lsb_unexpected_bit: got bit %b with nothing expected", so_l);
      end else begin
        e_l = q_l.pop_front();
        check2("lsb_bit", {so_l, sl_l}, e_l);
      end
    end else check1("lsb_last_without_valid", sl_l, 1'b0);
  end

  initial begin
    lv_m = 1'b0; lv_l = 1'b0; pi_m = '0; pi_l = '0;

    // Reset held with random load activity: outputs stay at reset values.
    repeat (2) begin
      @(posedge clk); #1;
      lv_m = 1'($urandom); pi_m = N'($urandom);
      lv_l = 1'($urandom); pi_l = N'($urandom);
      @(negedge clk);
      check_idle("reset");
    end
    @(posedge clk); #1;
    lv_m = 1'b0; lv_l = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle("post_reset");
    end

    // Single MSB-first word 1101 -> 1,1,0,1.
    @(posedge clk); #1;
    load(1'b0, 4'b1101);
    check1("single_busy", bz_m, 1'b1);
    check1("single_ready_mid", lr_m, 1'b0);
    repeat (F) @(posedge clk);
    #1;
    check_idle("single_done");

    // LSB-first word 1101 -> 1,0,1,1.
    load(1'b1, 4'b1101);
    check1("lsb_busy", bz_l, 1'b1);
    repeat (F) @(posedge clk);
    #1;
    check_idle("lsb_done");

    // Back-to-back: second word presented during the final-bit cycle.
    load(1'b0, 4'b1101);
    repeat (F-1) @(posedge clk);
    #1;
    check1("b2b_ready_last", lr_m, 1'b1);
    check1("b2b_last_flag", sl_m, 1'b1);
    load(1'b0, 4'b1010);
    repeat (F) begin
      check1("b2b_valid_contig", sv_m, 1'b1);
      @(posedge clk); #1;
    end
    check_idle("b2b_done");

    // Load attempt while busy is ignored.
    load(1'b0, 4'b1101);
    @(posedge clk); #1;
    lv_m = 1'b1; pi_m = 4'b0000;
    check1("busy_ready_low", lr_m, 1'b0);
    @(posedge clk); #1;
    lv_m = 1'b0;
    repeat (F-2) @(posedge clk);
    #1;
    check_idle("busy_done");

    // Reset mid-frame aborts without a last marker, then normal operation.
    load(1'b0, 4'b1010);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    q_m.delete();
    #1;
    check_idle("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    check_idle("midreset_release");
    load(1'b0, 4'b0110);
    repeat (F) @(posedge clk);
    #1;
    check_idle("after_reset_done");

    @(negedge clk);
    check1("msb_queue_drained", q_m.size() == 0, 1'b1);
    check1("lsb_queue_drained", q_l.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
